// File: rtl/laneswitch_ctrl_pkg.sv
// laneswitch_pkg: shared types and defaults for the laneswitch ownership
// controller (laneswitch_ctrl) and its drain timer.
package laneswitch_pkg;

  // Ownership FSM states; the encoding is also exported on state_dbg.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OWN0   = 3'd1,
    DRAIN0 = 3'd2,
    OWN1   = 3'd3,
    DRAIN1 = 3'd4
  } state_e;

  localparam int DEF_DRAIN_CYCLES   = 2;
  localparam int DEF_CNT_WIDTH      = 8;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  // Encoding of the laneswitch select.
  localparam logic LANE0_SEL = 1'b0;
  localparam logic LANE1_SEL = 1'b1;

  // True in the states where neither lane holds the buffer.
  function automatic logic is_drain(input state_e s);
    return (s == DRAIN0) || (s == DRAIN1);
  endfunction

endpackage

// File: rtl/laneswitch_drain_timer.sv
// laneswitch_drain_timer: counts consecutive idle cycles of the laneswitch
// `active` flag while the controller sits in a drain state.
// With LANESWITCH_CTRL_TIMEOUT_EN defined, it also hosts a drain watchdog
// that expires after TIMEOUT_CYCLES cycles in the drain state.
module laneswitch_drain_timer
  import laneswitch_pkg::*;
#(
  parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic active,
  output logic done,
  output logic wd_expired
);

  // Reject parameter values the counters cannot represent.
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("laneswitch_drain_timer: illegal DRAIN_CYCLES or TIMEOUT_CYCLES");
  end

  logic [3:0] idle_cnt;

  // done fires in the cycle that completes DRAIN_CYCLES idle cycles in a row.
  assign done = !clr && !active && (idle_cnt == 4'(DRAIN_CYCLES - 1));

  // Idle-run counter: any active cycle, a completed drain, or leaving the
  // drain state restarts the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= 4'd0;
    end else if (clr || active || done) begin
      idle_cnt <= 4'd0;
    end else begin
      idle_cnt <= idle_cnt + 4'd1;
    end
  end

`ifdef LANESWITCH_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // Expires in the TIMEOUT_CYCLES-th cycle spent in the drain state.
  assign wd_expired = !clr && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts every drain cycle regardless of active, cleared outside.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (clr) begin
      wd_cnt <= '0;
    end else if (!wd_expired) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  // No watchdog: drain states wait for the idle run indefinitely.
  assign wd_expired = 1'b0;
`endif

endmodule

// File: rtl/laneswitch_ctrl.sv
// laneswitch_ctrl: ping-pong ownership controller for the shared 2-port
// buffer in front of the laneswitch mux. Hands the buffer alternately to
// lane0 (producer) and lane1 (consumer) and drives the laneswitch select.
// Optional drain watchdog: define LANESWITCH_CTRL_TIMEOUT_EN.
//
// Lane protocol: a lane may issue memory requests only while its grant level
// is high; its start pulse marks the first cycle of a new grant. The owning
// lane hands the buffer back with a single-cycle done pulse, after which the
// grant drops on the next edge. The select only toggles once `active` has
// been low for DRAIN_CYCLES consecutive cycles. A done pulse from a lane that
// does not currently own the buffer is a protocol error (sticky proto_err).
module laneswitch_ctrl
  import laneswitch_pkg::*;
#(
  parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 active,
  input  logic                 fault,
  input  logic                 lane0_done,
  input  logic                 lane1_done,
  output logic                 switch,
  output logic                 lane0_grant,
  output logic                 lane1_grant,
  output logic                 lane0_start,
  output logic                 lane1_start,
  output logic [CNT_WIDTH-1:0] swap_cnt,
  output logic [CNT_WIDTH-1:0] fault_cnt,
  output logic                 proto_err,
  output logic                 timeout,
  output state_e               state_dbg
);

  state_e               state, state_n;
  logic                 switch_n;
  logic                 lane0_grant_n, lane1_grant_n;
  logic                 lane0_start_n, lane1_start_n;
  logic [CNT_WIDTH-1:0] swap_cnt_n;
  logic                 proto_err_n;
  logic                 drain_done;
  logic                 wd_expired;
  logic                 drain_go;

  assign state_dbg = state;
  assign drain_go  = drain_done || wd_expired;

  laneswitch_drain_timer #(
    .DRAIN_CYCLES   (DRAIN_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_drain_timer (
    .clk        (clk),
    .reset      (reset),
    .clr        (!is_drain(state)),
    .active     (active),
    .done       (drain_done),
    .wd_expired (wd_expired)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_n       = state;
    switch_n      = switch;
    lane0_grant_n = 1'b0;
    lane1_grant_n = 1'b0;
    lane0_start_n = 1'b0;
    lane1_start_n = 1'b0;
    swap_cnt_n    = swap_cnt;
    proto_err_n   = proto_err;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n       = OWN0;
          switch_n      = LANE0_SEL;
          lane0_grant_n = 1'b1;
          lane0_start_n = 1'b1;
        end
      end
      OWN0: begin
        lane0_grant_n = 1'b1;
        if (lane1_done) proto_err_n = 1'b1;
        if (lane0_done) begin
          state_n       = DRAIN0;
          lane0_grant_n = 1'b0;
        end
      end
      DRAIN0: begin
        if (lane0_done || lane1_done) proto_err_n = 1'b1;
        if (drain_go) begin
          state_n       = OWN1;
          switch_n      = LANE1_SEL;
          lane1_grant_n = 1'b1;
          lane1_start_n = 1'b1;
          swap_cnt_n    = swap_cnt + CNT_WIDTH'(1);
        end
      end
      OWN1: begin
        lane1_grant_n = 1'b1;
        if (lane0_done) proto_err_n = 1'b1;
        if (lane1_done) begin
          state_n       = DRAIN1;
          lane1_grant_n = 1'b0;
        end
      end
      DRAIN1: begin
        if (lane0_done || lane1_done) proto_err_n = 1'b1;
        if (drain_go) begin
          state_n       = OWN0;
          switch_n      = LANE0_SEL;
          lane0_grant_n = 1'b1;
          lane0_start_n = 1'b1;
          swap_cnt_n    = swap_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        switch_n = LANE0_SEL;
      end
    endcase
  end

  // State and output registers; reset returns the mux to lane0 at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      switch      <= LANE0_SEL;
      lane0_grant <= 1'b0;
      lane1_grant <= 1'b0;
      lane0_start <= 1'b0;
      lane1_start <= 1'b0;
      swap_cnt    <= '0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_n;
      switch      <= switch_n;
      lane0_grant <= lane0_grant_n;
      lane1_grant <= lane1_grant_n;
      lane0_start <= lane0_start_n;
      lane1_start <= lane1_start_n;
      swap_cnt    <= swap_cnt_n;
      proto_err   <= proto_err_n;
    end
  end

  // Fault cycles are counted in every state and saturate at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_cnt <= '0;
    end else if (fault && (fault_cnt != {CNT_WIDTH{1'b1}})) begin
      fault_cnt <= fault_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef LANESWITCH_CTRL_TIMEOUT_EN
  // Sticky watchdog flag, set on the edge of the forced toggle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout <= 1'b0;
    end else if (wd_expired) begin
      timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_laneswitch_ctrl.sv
// tb_laneswitch_ctrl: directed self-checking bench for laneswitch_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_laneswitch_ctrl;
  import laneswitch_pkg::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          active = 1'b0;
  logic          fault = 1'b0;
  logic          lane0_done = 1'b0;
  logic          lane1_done = 1'b0;
  logic          switch;
  logic          lane0_grant, lane1_grant;
  logic          lane0_start, lane1_start;
  logic [CW-1:0] swap_cnt, fault_cnt;
  logic          proto_err, timeout;
  state_e        state_dbg;

  int checks = 0;
  int failures = 0;

  laneswitch_ctrl #(
    .DRAIN_CYCLES   (2),
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .active      (active),
    .fault       (fault),
    .lane0_done  (lane0_done),
    .lane1_done  (lane1_done),
    .switch      (switch),
    .lane0_grant (lane0_grant),
    .lane1_grant (lane1_grant),
    .lane0_start (lane0_start),
    .lane1_start (lane1_start),
    .swap_cnt    (swap_cnt),
    .fault_cnt   (fault_cnt),
    .proto_err   (proto_err),
    .timeout     (timeout),
    .state_dbg   (state_dbg)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic apply_reset();
    enable = 0; active = 0; fault = 0; lane0_done = 0; lane1_done = 0;
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  // Enable pulse; returns on the falling edge where OWN0 is visible.
  task automatic start_run();
    enable = 1;
    @(negedge clk);
    enable = 0;
  endtask

  task automatic test_reset();
    enable = 0; active = 0; fault = 0; lane0_done = 0; lane1_done = 0;
    reset = 0;
    #12;
    checks++; if (switch !== 1'b0) begin failures++; $display("FAIL reset_switch: got %0b want 0", switch); end
    checks++; if (lane0_grant !== 1'b0 || lane1_grant !== 1'b0) begin failures++; $display("FAIL reset_grants: got %0b%0b want 00", lane0_grant, lane1_grant); end
    checks++; if (lane0_start !== 1'b0 || lane1_start !== 1'b0) begin failures++; $display("FAIL reset_starts: got %0b%0b want 00", lane0_start, lane1_start); end
    checks++; if (swap_cnt !== 8'd0 || fault_cnt !== 8'd0) begin failures++; $display("FAIL reset_counters: got %0d/%0d want 0/0", swap_cnt, fault_cnt); end
    checks++; if (proto_err !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL reset_flags: got %0b%0b want 00", proto_err, timeout); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
    @(negedge clk);
    reset = 1;
    // enable low: must stay idle
    @(negedge clk);
    @(negedge clk);
    checks++; if (lane0_grant !== 1'b0 || state_dbg !== IDLE) begin failures++; $display("FAIL idle_hold: got grant0=%0b state=%0d want 0/%0d", lane0_grant, state_dbg, IDLE); end
  endtask

  task automatic test_enable();
    start_run();
    checks++; if (lane0_grant !== 1'b1 || lane0_start !== 1'b1) begin failures++; $display("FAIL enable_grant_start: got %0b%0b want 11", lane0_grant, lane0_start); end
    checks++; if (switch !== 1'b0 || swap_cnt !== 8'd0) begin failures++; $display("FAIL enable_switch_swap: got %0b/%0d want 0/0", switch, swap_cnt); end
    checks++; if (lane1_grant !== 1'b0) begin failures++; $display("FAIL enable_grant1: got %0b want 0", lane1_grant); end
    @(negedge clk);
    checks++; if (lane0_start !== 1'b0 || lane0_grant !== 1'b1) begin failures++; $display("FAIL enable_start_pulse: got start=%0b grant=%0b want 0/1", lane0_start, lane0_grant); end
  endtask

  // Minimal drain both ways: select toggles 3 cycles after the done pulse.
  task automatic test_drain_min();
    lane0_done = 1;
    @(negedge clk);
    lane0_done = 0;
    checks++; if (lane0_grant !== 1'b0 || switch !== 1'b0) begin failures++; $display("FAIL drain0_c1: got grant0=%0b switch=%0b want 0/0", lane0_grant, switch); end
    @(negedge clk);
    checks++; if (lane0_grant !== 1'b0 || switch !== 1'b0 || lane1_grant !== 1'b0) begin failures++; $display("FAIL drain0_c2: got %0b/%0b/%0b want 0/0/0", lane0_grant, switch, lane1_grant); end
    @(negedge clk);
    checks++; if (switch !== 1'b1 || lane1_start !== 1'b1 || lane1_grant !== 1'b1) begin failures++; $display("FAIL drain0_toggle: got sw=%0b st1=%0b g1=%0b want 1/1/1", switch, lane1_start, lane1_grant); end
    checks++; if (swap_cnt !== 8'd1) begin failures++; $display("FAIL drain0_swap: got %0d want 1", swap_cnt); end
    @(negedge clk);
    checks++; if (lane1_start !== 1'b0 || lane1_grant !== 1'b1) begin failures++; $display("FAIL own1_start_pulse: got st1=%0b g1=%0b want 0/1", lane1_start, lane1_grant); end
    lane1_done = 1;
    @(negedge clk);
    lane1_done = 0;
    @(negedge clk);
    checks++; if (switch !== 1'b1 || lane1_grant !== 1'b0) begin failures++; $display("FAIL drain1_c2: got sw=%0b g1=%0b want 1/0", switch, lane1_grant); end
    @(negedge clk);
    checks++; if (switch !== 1'b0 || lane0_start !== 1'b1 || lane0_grant !== 1'b1) begin failures++; $display("FAIL drain1_toggle: got sw=%0b st0=%0b g0=%0b want 0/1/1", switch, lane0_start, lane0_grant); end
    checks++; if (swap_cnt !== 8'd2) begin failures++; $display("FAIL drain1_swap: got %0d want 2", swap_cnt); end
  endtask

  // Active traffic during drain with one idle gap: toggle needs 2 idle in a row.
  task automatic test_drain_active();
    logic act [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    lane0_done = 1;
    active = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      lane0_done = 0;
      checks++; if (switch !== 1'b0) begin failures++; $display("FAIL drain_active_hold[%0d]: got %0b want 0", i, switch); end
      active = act[i];
    end
    @(negedge clk);
    checks++; if (switch !== 1'b1 || lane1_start !== 1'b1) begin failures++; $display("FAIL drain_active_toggle: got sw=%0b st1=%0b want 1/1", switch, lane1_start); end
    checks++; if (swap_cnt !== 8'd3) begin failures++; $display("FAIL drain_active_swap: got %0d want 3", swap_cnt); end
    active = 0;
  endtask

  task automatic test_proto_err();
    apply_reset();
    start_run();
    lane1_done = 1;
    @(negedge clk);
    lane1_done = 0;
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_wrong_lane: got %0b want 1", proto_err); end
    checks++; if (state_dbg !== OWN0 || lane0_grant !== 1'b1 || switch !== 1'b0) begin failures++; $display("FAIL proto_state_kept: got st=%0d g0=%0b sw=%0b want %0d/1/0", state_dbg, lane0_grant, switch, OWN0); end
    fault = 1;
    repeat (100) @(negedge clk);
    checks++; if (fault_cnt !== 8'd100) begin failures++; $display("FAIL fault_count: got %0d want 100", fault_cnt); end
    repeat (200) @(negedge clk);
    fault = 0;
    checks++; if (fault_cnt !== 8'd255) begin failures++; $display("FAIL fault_saturate: got %0d want 255", fault_cnt); end
    @(negedge clk);
    checks++; if (fault_cnt !== 8'd255) begin failures++; $display("FAIL fault_hold: got %0d want 255", fault_cnt); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    start_run();
    lane0_done = 1;
    lane1_done = 1;
    @(negedge clk);
    lane0_done = 0;
    lane1_done = 0;
    checks++; if (state_dbg !== DRAIN0 || proto_err !== 1'b1) begin failures++; $display("FAIL simul_done: got st=%0d perr=%0b want %0d/1", state_dbg, proto_err, DRAIN0); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (switch !== 1'b1 || swap_cnt !== 8'd1) begin failures++; $display("FAIL simul_toggle: got sw=%0b swap=%0d want 1/1", switch, swap_cnt); end
  endtask

  task automatic test_back_to_back();
    int overlap = 0;
    int n;
    apply_reset();
    start_run();
    for (int i = 0; i < 300; i++) begin
      lane0_done = 1;
      @(negedge clk);
      lane0_done = 0;
      n = 0;
      while (switch !== 1'b1 && n < 10) begin
        if (lane0_grant === 1'b1 && lane1_grant === 1'b1) overlap++;
        @(negedge clk);
        n++;
      end
      checks++; if (switch !== 1'b1) begin failures++; $display("FAIL pingpong_to1[%0d]: got %0b want 1", i, switch); end
      lane1_done = 1;
      @(negedge clk);
      lane1_done = 0;
      n = 0;
      while (switch !== 1'b0 && n < 10) begin
        if (lane0_grant === 1'b1 && lane1_grant === 1'b1) overlap++;
        @(negedge clk);
        n++;
      end
      checks++; if (switch !== 1'b0) begin failures++; $display("FAIL pingpong_to0[%0d]: got %0b want 0", i, switch); end
    end
    checks++; if (swap_cnt !== 8'd88) begin failures++; $display("FAIL pingpong_swap_wrap: got %0d want 88", swap_cnt); end
    checks++; if (fault_cnt !== 8'd0) begin failures++; $display("FAIL pingpong_fault: got %0d want 0", fault_cnt); end
    checks++; if (overlap !== 0) begin failures++; $display("FAIL pingpong_grant_overlap: got %0d cycles want 0", overlap); end
  endtask

  // active stuck high in DRAIN0.
  task automatic test_watchdog();
    apply_reset();
    start_run();
    lane0_done = 1;
    active = 1;
    @(negedge clk);
    lane0_done = 0;
`ifdef LANESWITCH_CTRL_TIMEOUT_EN
    repeat (15) @(negedge clk);
    checks++; if (switch !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL wd_early: got sw=%0b tmo=%0b want 0/0", switch, timeout); end
    @(negedge clk);
    checks++; if (switch !== 1'b1 || lane1_start !== 1'b1 || timeout !== 1'b1) begin failures++; $display("FAIL wd_toggle: got sw=%0b st1=%0b tmo=%0b want 1/1/1", switch, lane1_start, timeout); end
    checks++; if (swap_cnt !== 8'd1) begin failures++; $display("FAIL wd_swap: got %0d want 1", swap_cnt); end
    active = 0;
    @(negedge clk);
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL wd_sticky: got %0b want 1", timeout); end
`else
    repeat (1000) @(negedge clk);
    checks++; if (switch !== 1'b0 || state_dbg !== DRAIN0) begin failures++; $display("FAIL no_wd_hold: got sw=%0b st=%0d want 0/%0d", switch, state_dbg, DRAIN0); end
    checks++; if (timeout !== 1'b0 || lane1_grant !== 1'b0) begin failures++; $display("FAIL no_wd_flags: got tmo=%0b g1=%0b want 0/0", timeout, lane1_grant); end
    active = 0;
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start_run();
    lane0_done = 1;
    @(negedge clk);
    lane0_done = 0;
    @(negedge clk);
    @(negedge clk);
    fault = 1;
    repeat (3) @(negedge clk);
    fault = 0;
    lane1_done = 1;
    active = 1;
    @(negedge clk);
    lane1_done = 0;
    lane0_done = 1;
    @(negedge clk);
    lane0_done = 0;
    checks++; if (proto_err !== 1'b1 || state_dbg !== DRAIN1) begin failures++; $display("FAIL drain_done_proto: got perr=%0b st=%0d want 1/%0d", proto_err, state_dbg, DRAIN1); end
    checks++; if (switch !== 1'b1 || swap_cnt !== 8'd1 || fault_cnt !== 8'd3) begin failures++; $display("FAIL pre_reset: got sw=%0b swap=%0d fc=%0d want 1/1/3", switch, swap_cnt, fault_cnt); end
    #2;
    reset = 0;
    #1;
    checks++; if (switch !== 1'b0 || lane0_grant !== 1'b0 || lane1_grant !== 1'b0) begin failures++; $display("FAIL async_reset_sel: got sw=%0b g=%0b%0b want 0/00", switch, lane0_grant, lane1_grant); end
    checks++; if (swap_cnt !== 8'd0 || fault_cnt !== 8'd0 || proto_err !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL async_reset_cnt: got %0d/%0d/%0b/%0b want 0/0/0/0", swap_cnt, fault_cnt, proto_err, timeout); end
    checks++; if (state_dbg !== IDLE || lane0_start !== 1'b0 || lane1_start !== 1'b0) begin failures++; $display("FAIL async_reset_state: got st=%0d starts=%0b%0b want %0d/00", state_dbg, lane0_start, lane1_start, IDLE); end
    active = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_enable();
    test_drain_min();
    test_drain_active();
    test_proto_err();
    test_simultaneous();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
